// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo read-side bridge.
package sync_fifo_pkg;

   localparam int unsigned READER_BUF_DEPTH = 3;
   localparam int unsigned OCC_WIDTH        = 2;
   localparam int unsigned PTR_WIDTH        = 2;

   typedef logic [OCC_WIDTH-1:0] occ_t;
   typedef logic [PTR_WIDTH-1:0] ptr_t;

   // Advance a buffer pointer modulo READER_BUF_DEPTH.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(READER_BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/sync_fifo_reader_skid_buf.sv
// Three-entry register queue with push/pop, occupancy and head-data output.
module reader_skid_buf
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output occ_t                  occ_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam occ_t OCC_FULL = occ_t'(READER_BUF_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [READER_BUF_DEPTH];
   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   occ_t occ_q, occ_d;
   logic do_push, do_pop;

   // Pointer and occupancy update; clear wins over push/pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      do_pop  = pop_i && (occ_q != '0) && !clear_i;
      do_push = push_i && !clear_i && ((occ_q != OCC_FULL) || do_pop);
      if (clear_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (do_push) tail_d = ptr_inc(tail_q);
         if (do_pop)  head_d = ptr_inc(head_q);
         case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < int'(READER_BUF_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         if (do_push) mem_q[tail_q] <= data_i;
      end
   end

   assign occ_o  = occ_q;
   assign data_o = mem_q[head_q];

endmodule

// File: rtl/sync_fifo_reader.sv
// Drains a one-cycle-latency FIFO read port into a valid/ready stream using
// credit-based issue into a three-entry output buffer.
module sync_fifo_reader
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  flush,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
);

   logic                 pending_q, pending_d;
   logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
   occ_t                 occ;
   logic [2:0]           credit_used;
   logic                 fire;

   // Buffered words plus the word in flight must leave room for one more.
   always_comb begin
      credit_used = 3'(occ) + 3'(pending_q);
      fifo_rd_en  = rst_n && !fifo_empty && !flush
                    && (credit_used < 3'(READER_BUF_DEPTH));
      m_valid     = (occ != '0);
      fire        = m_valid && m_ready;
      pending_d   = fifo_rd_en;
      xfer_cnt_d  = fire ? xfer_cnt_q + CNT_WIDTH'(1) : xfer_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         pending_q  <= pending_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (flush),
      .push_i  (pending_q),
      .data_i  (fifo_rd_data),
      .pop_i   (fire),
      .occ_o   (occ),
      .data_o  (m_data)
   );

   assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Randomized self-checking bench for sync_fifo_reader against a queue-based
// FIFO/stream model.
module tb_sync_fifo_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          flush;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [CW-1:0] xfer_cnt;

   always #5 clk = ~clk;

   sync_fifo_reader #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .xfer_cnt     (xfer_cnt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int xfers = 0;
   int rd_pulses = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] inflight;
   logic          inflight_v = 1'b0;
   logic          gate_mode  = 1'b0;

   logic          s_rd, s_hs, s_valid, s_empty;
   logic [DW-1:0] s_data;

   task automatic refresh_empty();
      fifo_empty = (fq.size() == 0) || (gate_mode && ((cyc / 2) % 2 == 1));
   endtask

   // One clock: sample at negedge against the model, advance model past posedge.
   task automatic tick();
      logic          exp_rd;
      logic [DW-1:0] w;
      @(negedge clk);
      s_rd    = fifo_rd_en;
      s_valid = m_valid;
      s_data  = m_data;
      s_empty = fifo_empty;
      s_hs    = m_valid && m_ready;
      exp_rd  = !fifo_empty && !flush && (sb.size() + int'(inflight_v) < 3);
      total++;
      if (s_rd !== exp_rd) begin
         bad++;
         $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, exp_rd);
      end
      total++;
      if (s_valid !== (sb.size() != 0)) begin
         bad++;
         $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, s_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
         total++;
         if (s_data !== sb[0]) begin
            bad++;
            $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, s_data, sb[0]);
         end
         if (m_ready) begin
            void'(sb.pop_front());
            xfers++;
         end
      end
      if (s_rd) rd_pulses++;
      @(posedge clk);
      #1;
      if (flush) sb.delete();
      else if (inflight_v) sb.push_back(inflight);
      inflight_v = s_rd && !flush;
      if (s_rd) begin
         w = (fq.size() != 0) ? fq.pop_front() : 8'hEE;
         fifo_rd_data = w;
         inflight     = w;
      end else begin
         fifo_rd_data = DW'($urandom);
      end
      cyc++;
      refresh_empty();
      total++;
      if (xfer_cnt !== CW'(xfers)) begin
         bad++;
         $display("FAIL xfer_cnt cyc=%0d got=%0d exp=%0d", cyc, xfer_cnt, CW'(xfers));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fifo_empty = 1'b0; flush = 1'b0; m_ready = 1'b1;
      fifo_rd_data = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total += 4;
         if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
         if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
         if (xfer_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
         if (m_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", m_data); end
      end
      for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
      @(posedge clk);
      #1;
      refresh_empty();
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      int c0 = cyc, first_rd = -1, first_v = -1, last_hs = -1, gaps = 0, start = xfers;
      m_ready = 1'b1;
      for (int i = 0; i < 40 && (xfers - start) < 8; i++) begin
         tick();
         if (s_rd && first_rd < 0) first_rd = cyc - 1;
         if (s_valid && first_v < 0) first_v = cyc - 1;
         if (s_hs) begin
            if (last_hs >= 0 && (cyc - 1) != last_hs + 1) gaps++;
            last_hs = cyc - 1;
         end
      end
      total += 4;
      if (first_rd != c0) begin bad++; $display("FAIL stream_first_rd got=%0d exp=%0d", first_rd, c0); end
      if (first_v - first_rd != 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", first_v - first_rd); end
      if (gaps != 0) begin bad++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
      if (xfer_cnt !== CW'(8)) begin bad++; $display("FAIL stream_cnt got=%0d exp=8", xfer_cnt); end
   endtask

   task automatic test_backpressure();
      int rd0 = rd_pulses, start, last_hs = -1, gaps = 0;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h10 + i));
      refresh_empty();
      repeat (10) tick();
      total += 2;
      if (rd_pulses - rd0 != 3) begin bad++; $display("FAIL bp_reads got=%0d exp=3", rd_pulses - rd0); end
      if (!(m_valid === 1'b1 && m_data === 8'h10)) begin
         bad++; $display("FAIL bp_hold got=%b/%h exp=1/10", m_valid, m_data);
      end
      m_ready = 1'b1;
      start = xfers;
      for (int i = 0; i < 30 && (xfers - start) < 8; i++) begin
         tick();
         if (s_hs) begin
            if (last_hs >= 0 && (cyc - 1) != last_hs + 1) gaps++;
            last_hs = cyc - 1;
         end
      end
      total += 2;
      if (xfers - start != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", xfers - start); end
      if (gaps != 0) begin bad++; $display("FAIL bp_gaps got=%0d exp=0", gaps); end
   endtask

   task automatic test_empty();
      int start = xfers, viol = 0;
      gate_mode = 1'b1;
      for (int i = 0; i < 16; i++) fq.push_back(DW'(8'hA0 + i));
      refresh_empty();
      for (int i = 0; i < 200 && (xfers - start) < 16; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         tick();
         if (s_rd && s_empty) viol++;
      end
      gate_mode = 1'b0;
      refresh_empty();
      total += 3;
      if (viol != 0) begin bad++; $display("FAIL empty_read got=%0d exp=0", viol); end
      if (xfers - start != 16) begin bad++; $display("FAIL empty_count got=%0d exp=16", xfers - start); end
      if (fq.size() != 0) begin bad++; $display("FAIL empty_left got=%0d exp=0", fq.size()); end
   endtask

   task automatic test_flush();
      logic [CW-1:0] cnt0;
      logic [DW-1:0] first_d = '0;
      logic          got = 1'b0;
      int start;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h30 + i));
      refresh_empty();
      repeat (3) tick();
      cnt0  = xfer_cnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total += 2;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", m_valid); end
      if (xfer_cnt !== cnt0) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", xfer_cnt, cnt0); end
      m_ready = 1'b1;
      start = xfers;
      for (int i = 0; i < 30 && (xfers - start) < 5; i++) begin
         tick();
         if (s_hs && !got) begin first_d = s_data; got = 1'b1; end
      end
      total += 2;
      if (first_d !== 8'h33) begin bad++; $display("FAIL flush_next got=%h exp=33", first_d); end
      if (xfers - start != 5) begin bad++; $display("FAIL flush_count got=%0d exp=5", xfers - start); end
   endtask

   task automatic test_reset_wrap();
      int start;
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) fq.push_back(DW'(8'h50 + i));
      refresh_empty();
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      total += 3;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", m_valid); end
      if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got=%b exp=0", fifo_rd_en); end
      if (xfer_cnt !== '0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", xfer_cnt); end
      sb.delete(); fq.delete(); inflight_v = 1'b0; xfers = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 17; i++) fq.push_back(DW'(8'h60 + i));
      refresh_empty();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      start   = xfers;
      for (int i = 0; i < 60 && (xfers - start) < 17; i++) tick();
      total += 2;
      if (xfers - start != 17) begin bad++; $display("FAIL wrap_count got=%0d exp=17", xfers - start); end
      if (xfer_cnt !== CW'(1)) begin bad++; $display("FAIL wrap_cnt got=%0d exp=1", xfer_cnt); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_empty();
      test_flush();
      test_reset_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_reader.md
# sync_fifo_reader

Read-side bridge that drains a `sync_fifo`-style read port (`rd_en`/`rd_data`/`empty`, one-cycle registered read latency) and presents the words on a valid/ready stream. A 3-entry output buffer with credit-based issue sustains one word per cycle while tolerating arbitrary downstream backpressure without losing or reordering data. It sits between any FIFO instance in the team's designs and a streaming consumer, such as a serializer or a DMA sink.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `CNT_WIDTH`, 16, width of the transfer counter.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data, valid in the cycle after `fifo_rd_en`.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_ready`  in  1  consumer accepts the word.
- `xfer_cnt`  out  CNT_WIDTH  count of completed stream transfers.

## Operation
- State:
  - `occ` (0..3): number of words held in the output buffer.
  - `pending` (0/1): set when `fifo_rd_en` was high in the previous cycle, meaning a word is on `fifo_rd_data` this cycle.
  - Buffer head and tail pointers, mod 3.
- Issue rule: `fifo_rd_en = !fifo_empty && !flush && (occ + pending < 3)`.
  - The rule has no combinational dependence on `m_ready`.
  - `fifo_rd_en` is forced to 0 while `rst_n` is low.
- Capture: if `pending` is set, `fifo_rd_data` is written at the tail on the clock edge.
- Pop: on `m_valid && m_ready`, the head advances.
  - Push and pop in the same cycle are both performed; `occ` is unchanged.
  - When `occ` is 0, push and pop never coincide, because `m_valid` is 0.
- `m_valid = (occ != 0)`; `m_data` = buffer[head].
  - While `m_valid && !m_ready`, `m_data` stays stable.
  - `m_valid` is never withdrawn before the word is accepted, except by `flush` or reset.
- No overflow is possible: the credit rule bounds `occ + pending` at 3.
- Flush:
  - On the next edge, `occ` and `pending` are cleared and the pointers are reset.
  - The word on `fifo_rd_data` that cycle is discarded.
  - `m_valid` is 0 in the following cycle.
  - `xfer_cnt` is not cleared.
- `xfer_cnt` increments by 1 on each `m_valid && m_ready`. It wraps modulo 2^CNT_WIDTH.
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `xfer_cnt` 0, `occ` 0, `pending` 0.
- Reset mid-operation: all buffered words are lost; no transfer completes in the cycle reset asserts.

## Timing
- Read latency: if `fifo_rd_en` is high in cycle t, the word is on `fifo_rd_data` in cycle t+1 and appears with `m_valid` high in cycle t+2.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty. The steady state is `occ=1`, `pending=1`.
- Backpressure: with `m_ready` held low, at most 3 reads are issued, then `fifo_rd_en` stays 0.
- First read: `fifo_rd_en` can assert in the first cycle after `rst_n` deasserts.

## Structure
- Shared package `sync_fifo_pkg` holds:
  - `READER_BUF_DEPTH = 3`;
  - the occupancy width (2 bits);
  - the pointer type.
- One sub-module: `reader_skid_buf`, a 3-entry register queue with push/pop, `occ`, and a head-data output.
- The top level contains the issue logic, the `pending` register, the `flush` handling and `xfer_cnt`.

## Test plan
- Reset: hold `rst_n`=0 with `fifo_empty`=0 → `fifo_rd_en`=0, `m_valid`=0, `xfer_cnt`=0 throughout.
- Streaming: FIFO preloaded with 0x01..0x08, `m_ready`=1 → `m_valid` first high 2 cycles after the first `fifo_rd_en`; 8 back-to-back beats 0x01..0x08; `xfer_cnt`=8.
- Backpressure: preload 0x10..0x17, `m_ready`=0 → exactly 3 `fifo_rd_en` pulses and `m_data`=0x10 held stable. Then `m_ready`=1 → 0x10..0x17 delivered in order with no gaps after the restart.
- Empty boundary: toggle `fifo_empty` every 2 cycles, supplying 0xA0.. → no `fifo_rd_en` while empty; output order and count are exact.
- Flush: `m_ready`=0, `occ`=2, `pending`=1, assert `flush` for 1 cycle → `m_valid`=0 the next cycle. After release, the next word out is the next FIFO entry; `xfer_cnt` is unchanged.
- Wrap: `CNT_WIDTH`=4, 17 transfers → `xfer_cnt`=1.
